// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: shadow-slot records
// for the EXE/MEM/WB stages, forwarding-select encodings and a select helper.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // Full record of an instruction sitting in EXE. Source fields are kept so
  // the forwarding selects for EXE operands can be derived locally.
  typedef struct packed {
    logic       v;
    logic       wb_en;
    logic       mem_r;
    logic [3:0] dest;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
  } slot_t;

  // MEM only needs writer identity plus the load flag (loads cannot forward
  // from MEM because their data is not ready yet).
  typedef struct packed {
    logic       v;
    logic       wb_en;
    logic       mem_r;
    logic [3:0] dest;
  } mem_slot_t;

  // WB only needs writer identity.
  typedef struct packed {
    logic       v;
    logic       wb_en;
    logic [3:0] dest;
  } wb_slot_t;

  localparam slot_t     SLOT_BUBBLE = '0;
  localparam mem_slot_t MEM_BUBBLE  = '0;
  localparam wb_slot_t  WB_BUBBLE   = '0;

  // MEM wins over WB because it holds the younger value; a load in MEM has
  // no result yet, so it falls through to the WB check.
  function automatic logic [1:0] fwd_pick(input logic mem_hit,
                                          input logic mem_is_load,
                                          input logic wb_hit);
    if (mem_hit && !mem_is_load) fwd_pick = FWD_MEM;
    else if (wb_hit)             fwd_pick = FWD_WB;
    else                         fwd_pick = FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-facing bundle of the hazard scoreboard.
// Handshake: id_valid qualifies every id_* field in the same cycle. hazard acts
// as the not-ready signal: the decoding instruction is taken into the EXE slot
// on a rising edge only when id_valid=1, hazard=0, flush=0 and freeze=0;
// otherwise decode must hold (or drop) it and a bubble enters EXE.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic             id_wb_en;
  logic             id_mem_r;
  logic [3:0]       id_dest;
  logic             flush;
  logic             freeze;
  logic             hazard;
  logic [1:0]       fwd_sel1;
  logic [1:0]       fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r,
           id_dest, flush, freeze,
    input  hazard, fwd_sel1, fwd_sel2, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r,
           id_dest, flush, freeze,
    output hazard, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_hs_match.sv
// Compares one in-flight writer slot against one source register. use_src
// gates whether the source is actually read this cycle.
module hazard_scoreboard_hs_match (
  input  logic       use_src,
  input  logic       v,
  input  logic       wb_en,
  input  logic [3:0] dest,
  input  logic [3:0] src,
  output logic       hit
);
  assign hit = use_src & v & wb_en & (dest == src);
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard/forwarding controller. Keeps its own EXE/MEM/WB shadow
// slots of in-flight writers, raises a combinational hazard for RAW conflicts
// and, with forwarding present, selects operand sources for the EXE stage.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b0,
  parameter bit WB_BYPASS  = 1'b1,
  parameter int CNT_W      = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);

  slot_t            exe_q;
  mem_slot_t        mem_q;
  wb_slot_t         wb_q;
  logic [CNT_W-1:0] cnt_q;

  logic use1, use2, exe_use1, exe_use2;
  logic id1_exe, id1_mem, id1_wb, id2_exe, id2_mem, id2_wb;
  logic e1_mem, e1_wb, e2_mem, e2_wb;
  logic raw_hit, load_use, hazard;
  logic [1:0] sel1, sel2;
  slot_t id_slot;

  assign use1     = bus.id_valid;
  assign use2     = bus.id_valid & bus.id_two_src;
  assign exe_use1 = exe_q.v;
  assign exe_use2 = exe_q.v & exe_q.two;

  // Decode sources against every slot.
  hazard_scoreboard_hs_match m_id1_exe (.use_src(use1), .v(exe_q.v), .wb_en(exe_q.wb_en),
    .dest(exe_q.dest), .src(bus.id_src1), .hit(id1_exe));
  hazard_scoreboard_hs_match m_id1_mem (.use_src(use1), .v(mem_q.v), .wb_en(mem_q.wb_en),
    .dest(mem_q.dest), .src(bus.id_src1), .hit(id1_mem));
  hazard_scoreboard_hs_match m_id1_wb  (.use_src(use1), .v(wb_q.v), .wb_en(wb_q.wb_en),
    .dest(wb_q.dest), .src(bus.id_src1), .hit(id1_wb));
  hazard_scoreboard_hs_match m_id2_exe (.use_src(use2), .v(exe_q.v), .wb_en(exe_q.wb_en),
    .dest(exe_q.dest), .src(bus.id_src2), .hit(id2_exe));
  hazard_scoreboard_hs_match m_id2_mem (.use_src(use2), .v(mem_q.v), .wb_en(mem_q.wb_en),
    .dest(mem_q.dest), .src(bus.id_src2), .hit(id2_mem));
  hazard_scoreboard_hs_match m_id2_wb  (.use_src(use2), .v(wb_q.v), .wb_en(wb_q.wb_en),
    .dest(wb_q.dest), .src(bus.id_src2), .hit(id2_wb));

  // EXE operands against the older writers, for forwarding.
  hazard_scoreboard_hs_match m_e1_mem (.use_src(exe_use1), .v(mem_q.v), .wb_en(mem_q.wb_en),
    .dest(mem_q.dest), .src(exe_q.s1), .hit(e1_mem));
  hazard_scoreboard_hs_match m_e1_wb  (.use_src(exe_use1), .v(wb_q.v), .wb_en(wb_q.wb_en),
    .dest(wb_q.dest), .src(exe_q.s1), .hit(e1_wb));
  hazard_scoreboard_hs_match m_e2_mem (.use_src(exe_use2), .v(mem_q.v), .wb_en(mem_q.wb_en),
    .dest(mem_q.dest), .src(exe_q.s2), .hit(e2_mem));
  hazard_scoreboard_hs_match m_e2_wb  (.use_src(exe_use2), .v(wb_q.v), .wb_en(wb_q.wb_en),
    .dest(wb_q.dest), .src(exe_q.s2), .hit(e2_wb));

  // Stall decision and forwarding selects; pure combinational from slots and ID.
  always_comb begin
    raw_hit  = id1_exe | id2_exe | id1_mem | id2_mem |
               (WB_BYPASS ? 1'b0 : (id1_wb | id2_wb));
    load_use = (id1_exe | id2_exe) & exe_q.mem_r;
    hazard   = FORWARD_EN ? load_use : raw_hit;
    sel1     = FORWARD_EN ? fwd_pick(e1_mem, mem_q.mem_r, e1_wb) : FWD_NONE;
    sel2     = FORWARD_EN ? fwd_pick(e2_mem, mem_q.mem_r, e2_wb) : FWD_NONE;
    id_slot  = '{v: 1'b1, wb_en: bus.id_wb_en, mem_r: bus.id_mem_r, dest: bus.id_dest,
                 s1: bus.id_src1, s2: bus.id_src2, two: bus.id_two_src};
  end

  // Shadow pipeline advance and stall counter, both held by freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q <= SLOT_BUBBLE;
      mem_q <= MEM_BUBBLE;
      wb_q  <= WB_BUBBLE;
      cnt_q <= '0;
    end else if (!bus.freeze) begin
      wb_q  <= '{v: mem_q.v, wb_en: mem_q.wb_en, dest: mem_q.dest};
      mem_q <= '{v: exe_q.v, wb_en: exe_q.wb_en, mem_r: exe_q.mem_r, dest: exe_q.dest};
      exe_q <= (hazard | bus.flush | ~bus.id_valid) ? SLOT_BUBBLE : id_slot;
      if (hazard && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.hazard    = hazard;
  assign bus.fwd_sel1  = sel1;
  assign bus.fwd_sel2  = sel2;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations share one stimulus stream.
//   u0: no forwarding, WB bypass   u1: forwarding, WB bypass
//   u2: no forwarding, no bypass, 3-bit stall counter (saturates at 7)
module tb_hazard_scoreboard;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  hazard_scoreboard_if #(.CNT_W(16)) b0 ();
  hazard_scoreboard_if #(.CNT_W(16)) b1 ();
  hazard_scoreboard_if #(.CNT_W(3))  b2 ();

  hazard_scoreboard #(.FORWARD_EN(1'b0), .WB_BYPASS(1'b1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  hazard_scoreboard #(.FORWARD_EN(1'b1), .WB_BYPASS(1'b1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1));
  hazard_scoreboard #(.FORWARD_EN(1'b0), .WB_BYPASS(1'b0), .CNT_W(3))  u2 (.clk(clk), .rst(rst), .bus(b2));

  logic       d_valid, d_two, d_wb, d_mr, d_flush, d_freeze;
  logic [3:0] d_s1, d_s2, d_dest;

  assign b0.id_valid = d_valid; assign b0.id_src1 = d_s1; assign b0.id_src2 = d_s2;
  assign b0.id_two_src = d_two; assign b0.id_wb_en = d_wb; assign b0.id_mem_r = d_mr;
  assign b0.id_dest = d_dest;   assign b0.flush = d_flush; assign b0.freeze = d_freeze;
  assign b1.id_valid = d_valid; assign b1.id_src1 = d_s1; assign b1.id_src2 = d_s2;
  assign b1.id_two_src = d_two; assign b1.id_wb_en = d_wb; assign b1.id_mem_r = d_mr;
  assign b1.id_dest = d_dest;   assign b1.flush = d_flush; assign b1.freeze = d_freeze;
  assign b2.id_valid = d_valid; assign b2.id_src1 = d_s1; assign b2.id_src2 = d_s2;
  assign b2.id_two_src = d_two; assign b2.id_wb_en = d_wb; assign b2.id_mem_r = d_mr;
  assign b2.id_dest = d_dest;   assign b2.flush = d_flush; assign b2.freeze = d_freeze;

  logic        dut_hz [3];
  logic [1:0]  dut_f1 [3];
  logic [1:0]  dut_f2 [3];
  logic [15:0] dut_cnt[3];
  assign dut_hz[0] = b0.hazard; assign dut_f1[0] = b0.fwd_sel1; assign dut_f2[0] = b0.fwd_sel2;
  assign dut_hz[1] = b1.hazard; assign dut_f1[1] = b1.fwd_sel1; assign dut_f2[1] = b1.fwd_sel2;
  assign dut_hz[2] = b2.hazard; assign dut_f1[2] = b2.fwd_sel1; assign dut_f2[2] = b2.fwd_sel2;
  assign dut_cnt[0] = b0.stall_cnt;
  assign dut_cnt[1] = b1.stall_cnt;
  assign dut_cnt[2] = {13'd0, b2.stall_cnt};

  // ---------------- scoreboard counters ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[c][age]: instructions accepted 1, 2, 3 edges ago (age 0 is the one
  // now executing). A producer at age a is "a+1 instructions ahead".
  typedef struct packed {
    logic       v;
    logic       wb;
    logic       mr;
    logic       two;
    logic [3:0] dest;
    logic [3:0] s1;
    logic [3:0] s2;
  } instr_t;

  instr_t hist [3][3];
  int     m_cnt[3];

  function automatic bit cfg_fwd(input int c); return c == 1; endfunction
  function automatic bit cfg_byp(input int c); return c != 2; endfunction
  function automatic int cfg_max(input int c); return (c == 2) ? 7 : 65535; endfunction

  function automatic bit writes(input int c, input int age, input logic [3:0] r);
    return hist[c][age].v && hist[c][age].wb && (hist[c][age].dest == r);
  endfunction

  function automatic bit m_hazard(input int c);
    bit hz;
    bit relevant;
    hz = 1'b0;
    for (int a = 0; a < 3; a++) begin
      if (cfg_fwd(c)) relevant = (a == 0) && hist[c][a].mr;
      else            relevant = (a < 2) || !cfg_byp(c);
      if (relevant && d_valid && writes(c, a, d_s1)) hz = 1'b1;
      if (relevant && d_valid && d_two && writes(c, a, d_s2)) hz = 1'b1;
    end
    return hz;
  endfunction

  function automatic int m_fwd(input int c, input int k);
    logic [3:0] r;
    if (!cfg_fwd(c) || !hist[c][0].v) return 0;
    if (k == 2 && !hist[c][0].two) return 0;
    r = (k == 1) ? hist[c][0].s1 : hist[c][0].s2;
    if (writes(c, 1, r) && !hist[c][1].mr) return 1;
    if (writes(c, 2, r)) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        for (int a = 0; a < 3; a++) hist[c][a] = '0;
        m_cnt[c] = 0;
      end
    end else if (!d_freeze) begin
      for (int c = 0; c < 3; c++) begin
        bit hz;
        hz = m_hazard(c);
        hist[c][2] = hist[c][1];
        hist[c][1] = hist[c][0];
        if (hz || d_flush || !d_valid) hist[c][0] = '0;
        else hist[c][0] = '{v: 1'b1, wb: d_wb, mr: d_mr, two: d_two,
                             dest: d_dest, s1: d_s1, s2: d_s2};
        if (hz && m_cnt[c] < cfg_max(c)) m_cnt[c]++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("cyc_hazard_u%0d", c), 32'(dut_hz[c]), 32'(m_hazard(c)));
      chk($sformatf("cyc_fwd1_u%0d", c), 32'(dut_f1[c]), m_fwd(c, 1));
      chk($sformatf("cyc_fwd2_u%0d", c), 32'(dut_f2[c]), m_fwd(c, 2));
      chk($sformatf("cyc_cnt_u%0d", c), 32'(dut_cnt[c]), m_cnt[c]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic v, input logic [3:0] dest, input logic [3:0] s1,
                        input logic [3:0] s2, input logic two, input logic wb, input logic mr);
    d_valid = v; d_dest = dest; d_s1 = s1; d_s2 = s2; d_two = two; d_wb = wb; d_mr = mr;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ADD r1,r2,r3 followed by SUB r2,r1,r3; consumer held until u2 releases.
  task automatic raw_pair();
    set_id(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    tick(1);
    set_id(1'b1, 4'd2, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0);
    tick(4);
    idle();
    tick(3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    d_flush = 1'b0;
    d_freeze = 1'b0;
    idle();
    @(posedge clk);
    #2;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("reset_hazard_u%0d", c), 32'(dut_hz[c]), 0);
      chk($sformatf("reset_cnt_u%0d", c), 32'(dut_cnt[c]), 0);
      chk($sformatf("reset_fwd1_u%0d", c), 32'(dut_f1[c]), 0);
    end
    rst = 1'b1;
    tick(1);

    // ADD r1 then SUB r2,r1,r3: two-cycle stall without forwarding.
    set_id(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    #1 chk("a_producer_no_hazard", 32'(dut_hz[0]), 0);
    tick(1);
    set_id(1'b1, 4'd2, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0);
    #1 chk("a_stall1_u0", 32'(dut_hz[0]), 1);
    tick(1);
    #1 chk("a_stall2_u0", 32'(dut_hz[0]), 1);
    chk("a_stall2_u2", 32'(dut_hz[2]), 1);
    tick(1);
    #1 chk("a_release_u0", 32'(dut_hz[0]), 0);
    chk("a_cnt_u0", 32'(dut_cnt[0]), 2);
    chk("a_wb_checked_u2", 32'(dut_hz[2]), 1);
    tick(1);
    #1 chk("a_release_u2", 32'(dut_hz[2]), 0);
    chk("a_cnt_u2", 32'(dut_cnt[2]), 3);
    tick(1);
    idle();
    tick(3);

    // LDR r4 then ADD r5,r4: one-cycle load-use stall, then WB forward.
    set_id(1'b1, 4'd4, 4'd6, 4'd0, 1'b0, 1'b1, 1'b1);
    tick(1);
    set_id(1'b1, 4'd5, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0);
    #1 chk("b_load_use_u1", 32'(dut_hz[1]), 1);
    tick(1);
    #1 chk("b_release_u1", 32'(dut_hz[1]), 0);
    chk("b_bubble_fwd1_u1", 32'(dut_f1[1]), 0);
    tick(1);
    idle();
    #1 chk("b_fwd1_wb_u1", 32'(dut_f1[1]), 2);
    chk("b_fwd2_one_src_u1", 32'(dut_f2[1]), 0);
    tick(3);

    // ADD r4; ADD r5,r4; ADD r6,r4: MEM forward then WB forward.
    set_id(1'b1, 4'd4, 4'd8, 4'd9, 1'b1, 1'b1, 1'b0);
    tick(1);
    set_id(1'b1, 4'd5, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0);
    #1 chk("c_no_stall_u1", 32'(dut_hz[1]), 0);
    tick(1);
    set_id(1'b1, 4'd6, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0);
    #1 chk("c_fwd1_mem_u1", 32'(dut_f1[1]), 1);
    tick(1);
    idle();
    #1 chk("c_fwd1_wb_u1", 32'(dut_f1[1]), 2);
    chk("c_fwd2_u1", 32'(dut_f2[1]), 0);
    tick(3);

    // Producer r7; consumer src2=r7 with two_src=0, src1=r0.
    set_id(1'b1, 4'd7, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0);
    tick(1);
    set_id(1'b1, 4'd8, 4'd0, 4'd7, 1'b0, 1'b1, 1'b0);
    #1;
    for (int c = 0; c < 3; c++) chk($sformatf("d_unread_src2_u%0d", c), 32'(dut_hz[c]), 0);
    tick(1);
    idle();
    #1 chk("d_fwd2_u1", 32'(dut_f2[1]), 0);
    chk("d_fwd1_u1", 32'(dut_f1[1]), 0);
    tick(3);

    // Flushed ADD r3 must not create a hazard for the next consumer of r3.
    set_id(1'b1, 4'd3, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0);
    d_flush = 1'b1;
    tick(1);
    d_flush = 1'b0;
    set_id(1'b1, 4'd9, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0);
    #1;
    for (int c = 0; c < 3; c++) chk($sformatf("e_flushed_u%0d", c), 32'(dut_hz[c]), 0);
    tick(1);
    idle();
    tick(3);

    // Asynchronous reset in the middle of a stall.
    set_id(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    tick(1);
    set_id(1'b1, 4'd2, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0);
    tick(1);
    #1 chk("g_mid_stall_u0", 32'(dut_hz[0]), 1);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("g_async_hazard_u%0d", c), 32'(dut_hz[c]), 0);
      chk($sformatf("g_async_cnt_u%0d", c), 32'(dut_cnt[c]), 0);
    end
    rst = 1'b1;
    idle();
    tick(3);

    // Freeze for 3 cycles during a stall.
    set_id(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    tick(1);
    set_id(1'b1, 4'd2, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0);
    #1 chk("f_stall_u0", 32'(dut_hz[0]), 1);
    tick(1);
    d_freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("f_frozen_hazard_u0", 32'(dut_hz[0]), 1);
      chk("f_frozen_cnt_u0", 32'(dut_cnt[0]), 1);
      chk("f_frozen_cnt_u2", 32'(dut_cnt[2]), 1);
      tick(1);
    end
    d_freeze = 1'b0;
    tick(1);
    #1 chk("f_release_u0", 32'(dut_hz[0]), 0);
    chk("f_cnt_u0", 32'(dut_cnt[0]), 2);
    chk("f_still_u2", 32'(dut_hz[2]), 1);
    tick(1);
    #1 chk("f_cnt_u2", 32'(dut_cnt[2]), 3);
    tick(1);
    idle();
    tick(3);

    // Further stalls push u2's 3-bit counter into saturation.
    raw_pair();
    raw_pair();
    chk("h_saturated_u2", 32'(dut_cnt[2]), 7);
    chk("h_cnt_u0", 32'(dut_cnt[0]), 6);
    chk("h_cnt_u1", 32'(dut_cnt[1]), 0);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
